// File: rtl/fx2_rotm_pipe.sv
// FX2 rotate-and-mask (logical right shift) pipeline: rotm/rotmh/rotmi/rothmi.
// Define FX2_ROTMA_EN to also claim the arithmetic forms (rotma/rotmah/rotmai/rotmahi).

package fx2_rotm_pkg;
  localparam logic [6:0] instr_ID_rotm    = 7'h58;
  localparam logic [6:0] instr_ID_rotmh   = 7'h59;
  localparam logic [6:0] instr_ID_rotmi   = 7'h5A;
  localparam logic [6:0] instr_ID_rothmi  = 7'h5B;
  localparam logic [6:0] instr_ID_rotma   = 7'h5C;
  localparam logic [6:0] instr_ID_rotmah  = 7'h5D;
  localparam logic [6:0] instr_ID_rotmai  = 7'h5E;
  localparam logic [6:0] instr_ID_rotmahi = 7'h5F;
endpackage

module fx2_rotm_pipe
  import fx2_rotm_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [6:0]       instr_id,
  input  logic [127:0]     ra_data,
  input  logic [127:0]     rb_data,
  input  logic [6:0]       imme7,
  input  logic [TAG_W-1:0] rt_addr,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_rt_addr,
  output logic [127:0]     out_result
);

  logic            claim_d;
  logic            half_d;
  logic            imm_d;
  logic            arith_d;
  logic [7:0][5:0] cnt_d;
  logic            s1_vld_d;

  logic             s1_vld_q;
  logic             s1_half_q;
  logic             s1_arith_q;
  logic [127:0]     s1_ra_q;
  logic [7:0][5:0]  s1_cnt_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [127:0]     s2_res_d;

  logic             p_vld_q [2:LATENCY];
  logic [TAG_W-1:0] p_tag_q [2:LATENCY];
  logic [127:0]     p_res_q [2:LATENCY];

  // Only the low count bits matter; the rest of RB and I7 bit 6 are ignored.
  logic unused_in;
  assign unused_in = ^{imme7[6], rb_data, s1_cnt_q};

  // Decode the instruction class; unclaimed IDs become bubbles.
  always_comb begin
    claim_d = 1'b0;
    half_d  = 1'b0;
    imm_d   = 1'b0;
    arith_d = 1'b0;
    unique case (1'b1)
      (instr_id == instr_ID_rotm): begin
        claim_d = 1'b1;
      end
      (instr_id == instr_ID_rotmh): begin
        claim_d = 1'b1;
        half_d  = 1'b1;
      end
      (instr_id == instr_ID_rotmi): begin
        claim_d = 1'b1;
        imm_d   = 1'b1;
      end
      (instr_id == instr_ID_rothmi): begin
        claim_d = 1'b1;
        half_d  = 1'b1;
        imm_d   = 1'b1;
      end
`ifdef FX2_ROTMA_EN
      (instr_id == instr_ID_rotma): begin
        claim_d = 1'b1;
        arith_d = 1'b1;
      end
      (instr_id == instr_ID_rotmah): begin
        claim_d = 1'b1;
        half_d  = 1'b1;
        arith_d = 1'b1;
      end
      (instr_id == instr_ID_rotmai): begin
        claim_d = 1'b1;
        imm_d   = 1'b1;
        arith_d = 1'b1;
      end
      (instr_id == instr_ID_rotmahi): begin
        claim_d = 1'b1;
        half_d  = 1'b1;
        imm_d   = 1'b1;
        arith_d = 1'b1;
      end
`endif
      default: ;
    endcase
    s1_vld_d = in_valid & claim_d;
  end

  // Per-slot right-shift counts: negated shift amount, modulo 64 or 32.
  always_comb begin
    cnt_d = '0;
    if (half_d) begin
      for (int h = 0; h < 8; h++) begin
        cnt_d[h] = {1'b0, 5'd0 - (imm_d ? imme7[4:0]
                                        : rb_data[112-16*h +: 5])};
      end
    end else begin
      for (int w = 0; w < 4; w++) begin
        cnt_d[w] = 6'd0 - (imm_d ? imme7[5:0]
                                 : rb_data[96-32*w +: 6]);
      end
    end
  end

  // Slot-local shifter; out-of-range counts give the fill value.
  always_comb begin
    s2_res_d = '0;
    if (s1_half_q) begin
      for (int h = 0; h < 8; h++) begin
        if (s1_cnt_q[h][4])
          s2_res_d[112-16*h +: 16] =
            {16{s1_arith_q & s1_ra_q[127-16*h]}};
        else if (s1_arith_q)
          s2_res_d[112-16*h +: 16] =
            $signed(s1_ra_q[112-16*h +: 16]) >>> s1_cnt_q[h][3:0];
        else
          s2_res_d[112-16*h +: 16] =
            s1_ra_q[112-16*h +: 16] >> s1_cnt_q[h][3:0];
      end
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (s1_cnt_q[w][5])
          s2_res_d[96-32*w +: 32] =
            {32{s1_arith_q & s1_ra_q[127-32*w]}};
        else if (s1_arith_q)
          s2_res_d[96-32*w +: 32] =
            $signed(s1_ra_q[96-32*w +: 32]) >>> s1_cnt_q[w][4:0];
        else
          s2_res_d[96-32*w +: 32] =
            s1_ra_q[96-32*w +: 32] >> s1_cnt_q[w][4:0];
      end
    end
  end

  // Valid bits: reset and flush clear, stall holds, else advance.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      s1_vld_q <= 1'b0;
      for (int k = 2; k <= LATENCY; k++) p_vld_q[k] <= 1'b0;
    end else if (!stall) begin
      s1_vld_q   <= s1_vld_d;
      p_vld_q[2] <= s1_vld_q;
      for (int k = 3; k <= LATENCY; k++) p_vld_q[k] <= p_vld_q[k-1];
    end
  end

  // Data registers advance whenever the pipe is not stalled.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_half_q  <= half_d;
      s1_arith_q <= arith_d;
      s1_ra_q    <= ra_data;
      s1_cnt_q   <= cnt_d;
      s1_tag_q   <= rt_addr;
      p_res_q[2] <= s2_res_d;
      p_tag_q[2] <= s1_tag_q;
      for (int k = 3; k <= LATENCY; k++) begin
        p_res_q[k] <= p_res_q[k-1];
        p_tag_q[k] <= p_tag_q[k-1];
      end
    end
  end

  assign out_valid   = p_vld_q[LATENCY];
  assign out_rt_addr = out_valid ? p_tag_q[LATENCY] : '0;
  assign out_result  = out_valid ? p_res_q[LATENCY] : '0;

endmodule
